pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline; drives the hold and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards, flushes wrong-path instructions on taken branches, and freezes the pipeline while the data memory is not ready. Tracks memory wait time with a timeout and keeps saturating performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 85 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for a 5-stage pipeline with memory-wait timeout and perf counters
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             MemRead_EX,
   input  logic [4:0]       writeAddr_EX,
   input  logic [4:0]       readAddr1_ID,
   input  logic [4:0]       readAddr2_ID,
   input  logic             usesRs_ID,
   input  logic             usesRt_ID,
   input  logic             branch_taken_EX,
   input  logic             mem_req_MEM,
   input  logic             mem_ready,
   output logic             stall_IF,
   output logic             stall_ID,
   output logic             stall_EX,
   output logic             stall_MEM,
   output logic             flush_ID,
   output logic             flush_EX,
   output logic             flush_WB,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   typedef enum logic {RUN, MEM_WAIT} state_t;
   state_t           state_q;
   logic [WW-1:0]    wait_q;
   logic             err_q;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic             hazard, mem_stall, timeout, full, br, lu;
   // hazard priority decode; memory freeze outranks branch flush, which outranks load-use
   always_comb begin
      hazard = MemRead_EX && (writeAddr_EX != 5'd0) &&
               ((usesRs_ID && readAddr1_ID == writeAddr_EX) || (usesRt_ID && readAddr2_ID == writeAddr_EX));
      mem_stall = mem_req_MEM && !mem_ready;
      timeout = (state_q == MEM_WAIT) && (wait_q >= WW'(MEM_TIMEOUT));
      full = (state_q == RUN) ? mem_stall : (!mem_ready && !timeout);
      br = (state_q == RUN) && !mem_stall && branch_taken_EX;
      lu = (state_q == RUN) && !mem_stall && !branch_taken_EX && hazard;
      stall_IF = !rst && (full || lu);
      stall_ID = !rst && (full || lu);
      stall_EX = !rst && full;
      stall_MEM = !rst && full;
      flush_ID = rst || br;
      flush_EX = rst || br || lu;
      flush_WB = rst || full;
      stall_cnt_d = ((full || lu) && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      flush_cnt_d = (br && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
   end
   // wait-state sequencing, sticky timeout flag and saturating counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         wait_q <= '0;
         err_q <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         if (state_q == RUN) begin
            if (mem_stall) begin
               state_q <= MEM_WAIT;
               wait_q <= WW'(1);
            end
         end else if (timeout) begin
            state_q <= RUN;
            wait_q <= '0;
            err_q <= 1'b1;
         end else if (mem_ready) begin
            state_q <= RUN;
            wait_q <= '0;
         end else begin
            wait_q <= wait_q + WW'(1);
         end
      end
   end
   assign mem_error = err_q;
   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
   logic clk = 1'b0;
   logic rst, MemRead_EX, usesRs_ID, usesRt_ID, branch_taken_EX, mem_req_MEM, mem_ready;
   logic [4:0] writeAddr_EX, readAddr1_ID, readAddr2_ID;
   logic stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, flush_WB, mem_error;
   logic [15:0] stall_count, flush_count;
   logic s_stall_IF, s_stall_ID, s_stall_EX, s_stall_MEM, s_flush_ID, s_flush_EX, s_flush_WB, s_mem_error;
   logic [3:0] s_stall_count, s_flush_count;
   logic [6:0] outs;
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .MemRead_EX(MemRead_EX), .writeAddr_EX(writeAddr_EX),
      .readAddr1_ID(readAddr1_ID), .readAddr2_ID(readAddr2_ID), .usesRs_ID(usesRs_ID),
      .usesRt_ID(usesRt_ID), .branch_taken_EX(branch_taken_EX), .mem_req_MEM(mem_req_MEM),
      .mem_ready(mem_ready), .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
      .stall_MEM(stall_MEM), .flush_ID(flush_ID), .flush_EX(flush_EX), .flush_WB(flush_WB),
      .mem_error(mem_error), .stall_count(stall_count), .flush_count(flush_count));

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .MemRead_EX(MemRead_EX), .writeAddr_EX(writeAddr_EX),
      .readAddr1_ID(readAddr1_ID), .readAddr2_ID(readAddr2_ID), .usesRs_ID(usesRs_ID),
      .usesRt_ID(usesRt_ID), .branch_taken_EX(branch_taken_EX), .mem_req_MEM(mem_req_MEM),
      .mem_ready(mem_ready), .stall_IF(s_stall_IF), .stall_ID(s_stall_ID), .stall_EX(s_stall_EX),
      .stall_MEM(s_stall_MEM), .flush_ID(s_flush_ID), .flush_EX(s_flush_EX), .flush_WB(s_flush_WB),
      .mem_error(s_mem_error), .stall_count(s_stall_count), .flush_count(s_flush_count));

   assign outs = {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, flush_WB};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      MemRead_EX = 0; writeAddr_EX = 0; readAddr1_ID = 0; readAddr2_ID = 0;
      usesRs_ID = 0; usesRt_ID = 0; branch_taken_EX = 0; mem_req_MEM = 0; mem_ready = 0;
   endtask

   task automatic load_use(input logic [4:0] wa, input logic [4:0] r1, input logic [4:0] r2, input logic urs, input logic urt);
      MemRead_EX = 1; writeAddr_EX = wa; readAddr1_ID = r1; readAddr2_ID = r2;
      usesRs_ID = urs; usesRt_ID = urt;
   endtask

   initial begin
      idle();
      rst = 1;
      #3 chk("rst_outs0", 32'(outs), 32'b0000111);
      tick();
      chk("rst_outs1", 32'(outs), 32'b0000111);
      tick();
      rst = 0;
      #3;
      chk("post_rst_outs", 32'(outs), 32'b0);
      chk("post_rst_cnt", {stall_count, flush_count}, 32'h0);
      chk("post_rst_err", 32'(mem_error), 32'h0);
      tick();
      load_use(5'd5, 5'd5, 5'd0, 1, 0);
      #3 chk("lu_rs", 32'(outs), 32'b1100010);
      tick();
      idle();
      #3 chk("lu_one_cycle", 32'(outs), 32'b0);
      chk("lu_cnt", 32'(stall_count), 32'd1);
      tick();
      load_use(5'd0, 5'd0, 5'd0, 1, 1);
      #3 chk("lu_r0", 32'(outs), 32'b0);
      tick();
      load_use(5'd7, 5'd3, 5'd7, 0, 1);
      #3 chk("lu_rt", 32'(outs), 32'b1100010);
      tick();
      load_use(5'd7, 5'd7, 5'd3, 0, 1);
      #3 chk("lu_rs_unused", 32'(outs), 32'b0);
      tick();
      load_use(5'd5, 5'd5, 5'd0, 1, 0);
      branch_taken_EX = 1;
      #3 chk("br_over_lu", 32'(outs), 32'b0000110);
      tick();
      idle();
      #3 chk("br_cnt", {stall_count, flush_count}, {16'd2, 16'd1});
      tick();
      mem_req_MEM = 1;
      #3 chk("mw_enter", 32'(outs), 32'b1111001);
      tick();
      branch_taken_EX = 1;
      #3 chk("mw_br_ignored", 32'(outs), 32'b1111001);
      tick();
      branch_taken_EX = 0;
      #3 chk("mw_wait3", 32'(outs), 32'b1111001);
      tick();
      mem_ready = 1;
      #3 chk("mw_ready", 32'(outs), 32'b0);
      tick();
      idle();
      #3 chk("mw_cnt", {stall_count, flush_count}, {16'd5, 16'd1});
      chk("mw_no_err", 32'(mem_error), 32'h0);
      tick();
      mem_req_MEM = 1;
      #3 chk("to_enter", 32'(outs), 32'b1111001);
      tick();
      for (int i = 1; i < 15; i++) begin
         #3 chk($sformatf("to_wait%0d", i), 32'(outs), 32'b1111001);
         tick();
      end
      #3 chk("to_drop", 32'(outs), 32'b0);
      chk("to_err_pending", 32'(mem_error), 32'h0);
      tick();
      mem_req_MEM = 0;
      #3 chk("to_run_outs", 32'(outs), 32'b0);
      chk("to_err", 32'(mem_error), 32'h1);
      chk("to_cnt", 32'(stall_count), 32'd20);
      chk("sat_cnt", 32'(s_stall_count), 32'd15);
      tick();
      load_use(5'd9, 5'd9, 5'd0, 1, 0);
      #3 chk("post_to_lu", 32'(outs), 32'b1100010);
      tick();
      idle();
      #3 chk("err_sticky", 32'(mem_error), 32'h1);
      chk("cnt21", 32'(stall_count), 32'd21);
      chk("sat_hold", 32'(s_stall_count), 32'd15);
      tick();
      mem_req_MEM = 1;
      tick();
      #3 chk("rst_mid_wait_pre", 32'(outs), 32'b1111001);
      rst = 1;
      #1 chk("rst_mid_wait", 32'(outs), 32'b0000111);
      tick();
      rst = 0;
      mem_req_MEM = 0;
      #3 chk("rst_abort_run", 32'(outs), 32'b0);
      chk("rst_abort_cnt", {stall_count, flush_count}, 32'h0);
      chk("rst_abort_err", 32'(mem_error), 32'h0);
      chk("rst_abort_sat", 32'(s_stall_count), 32'h0);
      branch_taken_EX = 1;
      #1 chk("rst_abort_br", 32'(outs), 32'b0000110);
      tick();
      idle();
      #3 chk("final_fcnt", 32'(flush_count), 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
